pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS core. It replaces the single-cycle PC register in the F stage.
- Holds the fetch PC and selects the next PC from four sources: exception entry, eret return, branch/jump redirect, and sequential increment.
- Supports pipeline stall. A redirect that arrives while stalled is captured in a pending buffer so it is not lost.
- Flags fetch-address faults (AdEL) for the CP0 exception logic.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).
- STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- stall  input  1  freeze the PC this cycle (from hazard unit)
- redir_valid  input  1  branch/jump taken, resolved in D stage
- redir_target  input  WIDTH  branch/jump target
- exc_req  input  1  exception/interrupt taken (from CP0)
- eret_req  input  1  eret committed
- epc  input  WIDTH  return address for eret
- pc  output  WIDTH  current fetch PC
- pc_plus_step  output  WIDTH  pc + STEP (combinational)
- pend_valid  output  1  a redirect is buffered
- adel  output  1  current pc misaligned or out of range (combinational)

Behaviour:
- Clocking: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- State: pc register, pend_valid, pend_target register.
- Reset values: pc=RESET_VECTOR, pend_valid=0, pend_target=0. Consequently pc_plus_step=RESET_VECTOR+STEP and adel=0 for default parameters.
- Reset has priority over every other input. A pending redirect is discarded on reset.
- Next-PC priority, evaluated each non-reset edge:
  1. exc_req: pc<=EXC_VECTOR; pend_valid<=0. Ignores stall.
  2. eret_req: pc<=epc; pend_valid<=0. Ignores stall.
  3. stall=1 and redir_valid=1: pc holds; pend_valid<=1; pend_target<=redir_target. A newer redirect overwrites an older pending one.
  4. stall=1, no redirect: pc holds; pending state holds.
  5. redir_valid=1: pc<=redir_target; pend_valid<=0. A live redirect wins over a pending one.
  6. pend_valid=1: pc<=pend_target; pend_valid<=0.
  7. Otherwise: pc<=pc+STEP.
- Latency:
  - Redirect, exception or eret asserted in cycle N is visible on pc in cycle N+1.
  - A buffered redirect appears one cycle after the first cycle with stall=0.
- Arithmetic: pc+STEP wraps modulo 2^WIDTH with no carry-out. Wrap-around is not special-cased; adel flags the result.
- adel = (pc[1:0]!=0) OR (pc<IMEM_BASE) OR (pc>IMEM_LIMIT). Comparisons are unsigned. adel does not alter sequencing; CP0 responds via exc_req.
- Targets and epc are loaded unmodified, including misaligned values; adel then reports the fault.
- exc_req and eret_req together: exc_req wins.

Test Plan:
- Reset for 2 cycles, then 3 free cycles -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; adel=0; pend_valid=0.
- At pc=0x3010, redir_valid=1, redir_target=0x3400 for 1 cycle -> next pc=0x3400, then 0x3404.
- Hold stall=1 for 3 cycles from pc=0x3020, with redir 0x3100 in stall cycle 1 and redir 0x3200 in stall cycle 2 -> pc stays 0x3020; pend_valid=1; pend_target=0x3200. First cycle after stall drops -> pc=0x3200, pend_valid=0.
- With stall=1 and pend_valid=1, assert exc_req -> pc=0x4180, pend_valid=0. Then eret_req with epc=0x3024 -> pc=0x3024.
- redir_target=0x3002 -> pc=0x3002, adel=1. redir_target=0x7000 -> adel=1. redir_target=0x6FFC -> adel=0, next pc 0x7000 with adel=1.
- Assert reset mid-stall with pend_valid=1 -> pc=0x3000, pend_valid=0 on the next edge. Sequential fetch resumes afterwards.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter for the pipelined MIPS core.
// Selects the next PC from exception entry, eret return, branch/jump redirect,
// or sequential increment. While stalled, a redirect is parked in a one-entry
// pending buffer and applied once the stall clears. adel flags fetch-address
// faults for CP0, which answers with exc_req.
module pc_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h0000_4180,
  parameter logic [WIDTH-1:0]  IMEM_BASE    = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  IMEM_LIMIT   = 32'h0000_6FFC,
  parameter logic [WIDTH-1:0]  STEP         = 32'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pend_valid,
  output logic             adel
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  // Sequential successor; wraps modulo 2^WIDTH, adel reports any fault.
  assign pc_plus_step = pc_q + STEP;

  // Next-state selection in strict priority order: exception, eret,
  // stall (capturing any redirect), live redirect, pending redirect, increment.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    pc_d          = pc_plus_step;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    if (exc_req) begin
      pc_d         = EXC_VECTOR;
      pend_valid_d = 1'b0;
    end else if (eret_req) begin
      pc_d         = epc;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
      if (redir_valid) begin
        // A newer redirect replaces an older buffered one.
        pend_valid_d  = 1'b1;
        pend_target_d = redir_target;
      end
    end else if (redir_valid) begin
      // A live redirect is younger than anything buffered, so it wins.
      pc_d         = redir_target;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      pc_d         = pend_target_q;
      pend_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset; reset discards
  // any pending redirect.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc         = pc_q;
  assign pend_valid = pend_valid_q;

  // Fetch-address fault: misaligned word or outside instruction memory.
  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q > IMEM_LIMIT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed test-plan sequences followed by
// randomized traffic. A driver applies one input vector per cycle and pushes
// the reference model's expected post-edge outputs; a monitor pops and
// compares after every rising edge.
module tb_pc_unit;

  localparam logic [31:0] RST_V = 32'h0000_3000;
  localparam logic [31:0] EXC_V = 32'h0000_4180;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] LIMIT = 32'h0000_6FFC;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        pend_valid;
  logic        adel;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .pc           (pc),
    .pc_plus_step (pc_plus_step),
    .pend_valid   (pend_valid),
    .adel         (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pps;
    logic        pv;
    logic        adel;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          step_no     = 0;

  // Reference model state: what the PC unit should be holding.
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_pt;

  function automatic logic fault(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || (a > LIMIT);
  endfunction

  // Apply one vector for one cycle and predict the result after the edge.
  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [31:0] rt, input logic e, input logic er,
                      input logic [31:0] ep);
    exp_t x;
    @(negedge clk);
    reset = r; stall = s; redir_valid = rv; redir_target = rt;
    exc_req = e; eret_req = er; epc = ep;
    if (r)              begin m_pc = RST_V; m_pv = 1'b0; m_pt = 32'h0; end
    else if (e)         begin m_pc = EXC_V; m_pv = 1'b0; end
    else if (er)        begin m_pc = ep;    m_pv = 1'b0; end
    else if (s && rv)   begin m_pv = 1'b1;  m_pt = rt;   end
    else if (s)         begin end
    else if (rv)        begin m_pc = rt;    m_pv = 1'b0; end
    else if (m_pv)      begin m_pc = m_pt;  m_pv = 1'b0; end
    else                m_pc = m_pc + 32'd4;
    x.pc   = m_pc;
    x.pps  = m_pc + 32'd4;
    x.pv   = m_pv;
    x.adel = fault(m_pc);
    sb_q.push_back(x);
    step_no++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic redir(input logic [31:0] t);
    step(1'b0, 1'b0, 1'b1, t, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest
  // prediction.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      vectors++;
      if (pc !== x.pc || pc_plus_step !== x.pps || pend_valid !== x.pv || adel !== x.adel) begin
        miscompares++;
        $display("FAIL outputs@t=%0t: got pc=%h pps=%h pend=%b adel=%b, want pc=%h pps=%h pend=%b adel=%b",
                 $time, pc, pc_plus_step, pend_valid, adel, x.pc, x.pps, x.pv, x.adel);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;
    m_pc = RST_V; m_pv = 1'b0; m_pt = '0;

    // Reset for two cycles, then free-run to 0x3010.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (4) idle();                         // 3004, 3008, 300C, 3010
    redir(32'h0000_3400);                      // -> 3400
    idle();                                    // -> 3404

    // Stall window with two redirects; the newer one must win.
    redir(32'h0000_3020);
    step(1'b0, 1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0);
    idle();                                    // -> 3200
    idle();                                    // -> 3204

    // Exception during stall with a pending redirect, then eret.
    step(1'b0, 1'b1, 1'b1, 32'h0000_3300, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_3024);
    idle();
    // exc_req and eret_req together: exception wins.
    step(1'b0, 1'b0, 1'b1, 32'h0000_3500, 1'b1, 1'b1, 32'h0000_3600);
    // Live redirect beats a pending one.
    step(1'b0, 1'b1, 1'b1, 32'h0000_3700, 1'b0, 1'b0, 32'h0);
    redir(32'h0000_3800);
    idle();

    // Address-fault boundaries.
    redir(32'h0000_3002);
    redir(32'h0000_7000);
    redir(32'h0000_2FFC);
    redir(32'h0000_3000);
    redir(32'h0000_6FFC);
    idle();                                    // -> 7000, adel
    // Wrap-around of the increment.
    redir(32'hFFFF_FFFC);
    idle();                                    // -> 0000_0000

    // Reset mid-stall with a pending redirect, then resume.
    step(1'b0, 1'b1, 1'b1, 32'h0000_3900, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0);
    repeat (3) idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      logic [31:0] ep;
      t  = ($urandom_range(0, 7) == 0) ? $urandom : (BASE + ($urandom_range(0, 32'h0FFF) << 2));
      ep = ($urandom_range(0, 7) == 0) ? $urandom : (BASE + ($urandom_range(0, 32'h0FFF) << 2));
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0,
           t,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0,
           ep);
    end

    @(posedge clk);
    #2;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked predictions, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
